// File: rtl/pooling_stream.sv
// Streaming KxK non-overlapping max/average pooling with a per-window line buffer.
// Define POOL_RELU_EN to clamp negative pooled results to zero.
module pooling_stream #(
  parameter int data_width = 16,
  parameter int K          = 2,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [data_width-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [data_width-1:0] out_data,
  output logic                         out_last,
  output logic                         busy
);

  localparam int LK    = $clog2(K);
  localparam int ACC_W = data_width + 2 * LK;
  localparam int WINS  = IMG_W / K;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int WW    = (WINS > 1) ? $clog2(WINS) : 1;

  function automatic logic signed [ACC_W-1:0] f_combine(
    input logic                    m,
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    if (m) return a + b;
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [data_width-1:0] f_pool(
    input logic                    m,
    input logic signed [ACC_W-1:0] r
  );
    logic signed [ACC_W-1:0] s;
    s = m ? (r >>> (2 * LK)) : r;
`ifdef POOL_RELU_EN
    if (s < 0) s = '0;
`else
`endif
    return data_width'(s);
  endfunction

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic                         r_mode;
  logic                         r_busy;
  logic                         r_out_valid;
  logic signed [data_width-1:0] r_out_data;
  logic                         r_out_last;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [ACC_W-1:0]      r_buf [2**WW];

  logic                         w_fire;
  logic [LK-1:0]                w_kc;
  logic [LK-1:0]                w_kr;
  logic [WW-1:0]                w_win;
  logic signed [ACC_W-1:0]      w_x;
  logic signed [ACC_W-1:0]      w_acc_fin;
  logic signed [ACC_W-1:0]      w_comb;
  logic                         w_kc_end;
  logic                         w_kr_end;
  logic                         w_kr_zero;
  logic                         w_col_end;
  logic                         w_row_end;
  logic                         w_emit;

  assign in_ready  = r_busy & ~(r_out_valid & ~out_ready);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  // A start pulse owns its cycle: no sample is taken while the frame restarts.
  assign w_fire    = in_valid & in_ready & ~start;
  assign w_kc      = r_col[LK-1:0];
  assign w_kr      = r_row[LK-1:0];
  assign w_win     = WW'(r_col >> LK);
  assign w_x       = {{(2 * LK){in_data[data_width-1]}}, in_data};
  assign w_acc_fin = (w_kc == '0) ? w_x : f_combine(r_mode, r_acc, w_x);
  assign w_comb    = f_combine(r_mode, r_buf[w_win], w_acc_fin);
  assign w_kc_end  = (w_kc == LK'(K - 1));
  assign w_kr_end  = (w_kr == LK'(K - 1));
  assign w_kr_zero = (w_kr == '0);
  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));
  assign w_emit    = w_fire & w_kc_end & w_kr_end;

  // Accumulate stage: horizontal partial in r_acc, vertical partial per window in r_buf.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_acc <= w_acc_fin;
      if (w_kc_end && !w_kr_end)
        r_buf[w_win] <= w_kr_zero ? w_acc_fin : w_comb;
    end
  end

  // Output stage: one registered result per completed window, held until accepted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (start) begin
      r_col       <= '0;
      r_row       <= '0;
      r_mode      <= mode;
      r_busy      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_fire) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= f_pool(r_mode, w_comb);
        r_out_last  <= w_col_end & w_row_end;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_last  <= 1'b0;
      end
      if (r_out_valid && out_ready && r_out_last)
        r_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pooling_stream.sv
// Directed bench for pooling_stream: a 4x2 K=2 instance and a 4x4 K=4 instance.
module tb_pooling_stream;

`ifdef POOL_RELU_EN
  localparam int AVG1 = 0;
`else
  localparam int AVG1 = -1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               nrst, start, mode, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [15:0] in_data, out_data;
  logic               b_start, b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic signed [15:0] b_in_data, b_out_data;

  pooling_stream #(.data_width(16), .K(2), .IMG_W(4), .IMG_H(2)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  pooling_stream #(.data_width(16), .K(4), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .start(b_start), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int qd[$];
  int ql[$];
  int bqd[$];
  int bql[$];
  int fr[8] = '{1, 5, -3, 2, 4, 0, 7, -8};

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      qd.push_back(int'(out_data));
      ql.push_back(int'(out_last));
    end
    if (b_out_valid && b_out_ready) begin
      bqd.push_back(int'(b_out_data));
      bql.push_back(int'(b_out_last));
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m);
    mode  = m;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push(input int x);
    logic ok;
    int   t;
    in_valid = 1'b1;
    in_data  = 16'(x);
    t = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      tick(1);
      t++;
    end while (!ok && t < 100);
    if (!ok) chk("push_ready", in_ready, 1);
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) push(fr[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while ((qd.size() < n || busy) && t < 60) begin
      tick(1);
      t++;
    end
  endtask

  task automatic check_frame(input string tag, input int e0, input int e1);
    chk({tag, "_count"}, qd.size(), 2);
    if (qd.size() == 2) begin
      chk({tag, "_d0"}, qd[0], e0);
      chk({tag, "_l0"}, ql[0], 0);
      chk({tag, "_d1"}, qd[1], e1);
      chk({tag, "_l1"}, ql[1], 1);
    end
    chk({tag, "_busy"}, busy, 0);
    qd.delete();
    ql.delete();
  endtask

  initial begin
    int acc;
    int t;
    logic ok;
    nrst = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_start = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    nrst = 1'b1;
    tick(2);

    do_start(1'b0);
    send_n(8);
    wait_done(2);
    check_frame("max", 5, 7);

    do_start(1'b1);
    send_n(8);
    wait_done(2);
    check_frame("avg", 2, AVG1);

    out_ready = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < 6; i++) push(fr[i]);
    in_data = 16'sd7;
    tick(3);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, 5);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_none_taken", qd.size(), 0);
    out_ready = 1'b1;
    push(7);
    push(-8);
    in_valid = 1'b0;
    wait_done(2);
    check_frame("bp", 5, 7);

    do_start(1'b0);
    send_n(5);
    tick(1);
    do_start(1'b1);
    send_n(8);
    wait_done(2);
    check_frame("abort", 2, AVG1);

    out_ready = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < 6; i++) push(fr[i]);
    in_valid = 1'b0;
    tick(1);
    chk("rst_pre_out_valid", out_valid, 1);
    #2 nrst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data, 0);
    #10 nrst = 1'b1;
    tick(2);
    in_valid = 1'b1;
    in_data  = 16'sd3;
    #1;
    chk("arst_in_ready", in_ready, 0);
    tick(2);
    chk("arst_idle_busy", busy, 0);
    chk("arst_no_output", qd.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(1);

    b_mode  = 1'b1;
    b_start = 1'b1;
    tick(1);
    b_start    = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = 16'sd7;
    acc = 0;
    t = 0;
    while (acc < 16 && t < 100) begin
      @(negedge clk);
      ok = b_in_ready;
      tick(1);
      if (ok) acc++;
      t++;
    end
    b_in_valid = 1'b0;
    chk("k4_accepted", acc, 16);
    t = 0;
    while ((bqd.size() < 1 || b_busy) && t < 40) begin
      tick(1);
      t++;
    end
    chk("k4_count", bqd.size(), 1);
    if (bqd.size() == 1) begin
      chk("k4_data", bqd[0], 7);
      chk("k4_last", bql[0], 1);
    end
    chk("k4_busy", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
